apb_gpio_completer: RTL and testbench
=====================================

Name: apb_gpio_completer

Overview:
APB completer (slave) terminating the team's APB interface and owning the GPIO register map. Decodes APB transfers from the UVM APB agent or any requester, inserts a configurable number of wait states, and returns PRDATA/PREADY/PSLVERR. Drives gpio_out/gpio_oe and samples a synchronised gpio_in. Sits between the APB interconnect and the GPIO pads; it is the DUT-side partner of the APB agent.

Parameters:
PADDR_SIZE, 32, APB address width
PDATA_SIZE, 32, APB data width; PSTRB width = PDATA_SIZE/8
GPIO_WIDTH, 32, number of GPIO pins; must be <= PDATA_SIZE
WAIT_STATES, 0, access cycles with PREADY low before the completing cycle (0..15)
BASE_ADDR, 0, byte address of register offset 0x00

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  asynchronous active-low reset
PSEL  input  1  completer select
PENABLE  input  1  access phase
PADDR  input  PADDR_SIZE  byte address
PWRITE  input  1  1 = write
PSTRB  input  PDATA_SIZE/8  write byte strobes
PWDATA  input  PDATA_SIZE  write data
PRDATA  output  PDATA_SIZE  read data
PREADY  output  1  transfer complete
PSLVERR  output  1  transfer error
gpio_in  input  GPIO_WIDTH  asynchronous pad inputs
gpio_out  output  GPIO_WIDTH  pad output values
gpio_oe  output  GPIO_WIDTH  pad output enables, 1 = drive

Behaviour:
- Reset (rst low, async): all outputs 0; OUT, OE, synchroniser flops 0; FSM to IDLE; wait counter 0. Reset mid-transfer aborts it with no register update.
- Register map (offset = PADDR - BASE_ADDR): 0x00 OUT (RW, drives gpio_out), 0x04 OE (RW, drives gpio_oe), 0x08 IN (RO, synchronised gpio_in). Bits above GPIO_WIDTH read 0, writes ignored.
- FSM IDLE -> WAIT -> DONE -> IDLE. PREADY, PRDATA and PSLVERR are registered.
- IDLE: at an edge with PSEL=1, PENABLE=0, latch PADDR/PWRITE/PSTRB/PWDATA and load counter = WAIT_STATES. Go to DONE if WAIT_STATES=0, else WAIT.
- WAIT: decrement each edge while PSEL=1. Go to DONE when counter reaches 1.
- DONE: PREADY=1 for exactly one cycle, i.e. access cycle number WAIT_STATES+1. Zero-wait transfer is 2 cycles total.
- PRDATA holds read data only in the PREADY cycle, otherwise 0. PSLVERR is valid only with PREADY, otherwise 0.
- Write commit: OUT/OE update at the edge ending the PREADY cycle, per byte lane where PSTRB[i]=1. PSTRB is ignored on reads.
- Error (PSLVERR=1 with PREADY, no state change, PRDATA=0):
  - PADDR[1:0] != 0
  - offset outside the map
  - write to IN
- PSEL dropped before PREADY: abort to IDLE, no write, PREADY stays 0.
- Back-to-back: a setup phase in the cycle after DONE is accepted normally, with no idle cycle required.
- gpio_in: 2-flop synchroniser. IN reflects a pin change 2 edges later.

Optional Feature:
Macro APB_GPIO_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, reset 0).
  - Adds 0x0C IRQ_EN (RW) and 0x10 IRQ_STAT (W1C).
  - A rising edge on a synchronised input bit sets its IRQ_STAT bit.
  - irq = |(IRQ_STAT & IRQ_EN), registered.
  - If a set and a W1C clear hit the same bit in the same cycle, set wins.
- Undefined: no irq port; offsets 0x0C and 0x10 return PSLVERR.

Test Plan:
- Reset, then read 0x00/0x04/0x08 with WAIT_STATES=0 and gpio_in=0 -> PRDATA=0, PSLVERR=0, PREADY in the first access cycle.
- Write 0xDEADBEEF to 0x00 with PSTRB=4'b0101 -> gpio_out=0x00AD00EF after commit edge; readback returns the same value.
- WAIT_STATES=3: write 0xFF to 0x04 -> PREADY low for 3 access cycles, high on the 4th; gpio_oe=0xFF only after that edge.
- Write to 0x08, read 0x14, read 0x02 -> each completes with PSLVERR=1, PRDATA=0, OUT/OE unchanged.
- gpio_in 0 -> 0xA5A5A5A5 -> read 0x08 on the 3rd edge after the change returns 0xA5A5A5A5; PSEL dropped mid-WAIT -> no PREADY, FSM back in IDLE.
- APB_GPIO_IRQ_EN: IRQ_EN=0x1, pulse gpio_in[0] -> irq=1; write 0x1 to 0x10 -> irq=0 within 2 cycles.

Source files
------------

// File: rtl/apb_gpio_completer.sv
// apb_gpio_completer: APB completer owning the GPIO OUT/OE/IN register map.
// Define APB_GPIO_IRQ_EN to add IRQ_EN (0x0C), IRQ_STAT (0x10, W1C) and the irq output.
module apb_gpio_completer #(
    parameter int                    PADDR_SIZE  = 32,
    parameter int                    PDATA_SIZE  = 32,
    parameter int                    GPIO_WIDTH  = 32,
    parameter int                    WAIT_STATES = 0,
    parameter logic [PADDR_SIZE-1:0] BASE_ADDR   = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic                    PWRITE,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    input  logic [GPIO_WIDTH-1:0]   gpio_in,
    output logic [GPIO_WIDTH-1:0]   gpio_out,
    output logic [GPIO_WIDTH-1:0]   gpio_oe
`ifdef APB_GPIO_IRQ_EN
    ,
    output logic                    irq
`endif
);
    localparam int SW = PDATA_SIZE / 8;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [PADDR_SIZE-1:0] addr_q, req_addr, offset;
    logic                  write_q, req_write;
    logic [SW-1:0]         strb_q;
    logic [PDATA_SIZE-1:0] wdata_q, lane_mask, rdata;
    logic [GPIO_WIDTH-1:0] out_q, out_d, oe_q, oe_d, sync1_q, sync2_q;
    logic [GPIO_WIDTH-1:0] wmask, wbits, rd;
    logic                  pready_q, pready_d, pslverr_q, pslverr_d;
    logic [PDATA_SIZE-1:0] prdata_q, prdata_d;
    logic                  accept, commit, err;
    logic                  hit_out, hit_oe, hit_in, hit_ien, hit_ist;

    for (genvar i = 0; i < SW; i++) begin : g_lane
        assign lane_mask[i*8 +: 8] = {8{strb_q[i]}};
    end

    assign wmask = lane_mask[GPIO_WIDTH-1:0];
    assign wbits = wdata_q[GPIO_WIDTH-1:0];

    // A setup phase is only recognised while idle; later phases use the latched request.
    assign accept    = state_q == IDLE && PSEL && !PENABLE;
    assign req_addr  = state_q == IDLE ? PADDR : addr_q;
    assign req_write = state_q == IDLE ? PWRITE : write_q;
    assign offset    = req_addr - BASE_ADDR;

    assign hit_out = offset == PADDR_SIZE'(0);
    assign hit_oe  = offset == PADDR_SIZE'(4);
    assign hit_in  = offset == PADDR_SIZE'(8);

    assign err = req_addr[1:0] != 2'b00
               || !(hit_out || hit_oe || hit_in || hit_ien || hit_ist)
               || (req_write && hit_in);

    // The error flag of the transfer in DONE is already held in pslverr_q.
    assign commit = state_q == DONE && write_q && !pslverr_q;
    assign out_d  = commit && hit_out ? (out_q & ~wmask) | (wbits & wmask) : out_q;
    assign oe_d   = commit && hit_oe ? (oe_q & ~wmask) | (wbits & wmask) : oe_q;

`ifdef APB_GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] sync3_q, ien_q, ien_d, ist_q, ist_d;
    logic                  irq_q;

    assign hit_ien = offset == PADDR_SIZE'(12);
    assign hit_ist = offset == PADDR_SIZE'(16);
    assign ien_d   = commit && hit_ien ? (ien_q & ~wmask) | (wbits & wmask) : ien_q;
    // Rising edges are ORed in after the clear so a same-cycle set survives.
    assign ist_d   = (ist_q & ~(commit && hit_ist ? wbits & wmask : '0)) | (sync2_q & ~sync3_q);
    assign irq     = irq_q;

    // Edge-detect history, interrupt registers and the registered irq line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync3_q <= '0;
            ien_q   <= '0;
            ist_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync3_q <= sync2_q;
            ien_q   <= ien_d;
            ist_q   <= ist_d;
            irq_q   <= |(ist_q & ien_q);
        end
    end
`else
    assign hit_ien = 1'b0;
    assign hit_ist = 1'b0;
`endif

    // Read mux uses next-state register values so a read right after a write sees it.
    always_comb begin
        rd = hit_out ? out_d : hit_oe ? oe_d : sync2_q;
`ifdef APB_GPIO_IRQ_EN
        rd = hit_ien ? ien_d : hit_ist ? ist_d : rd;
`endif
        rdata = '0;
        rdata[GPIO_WIDTH-1:0] = rd;
    end

    // FSM state register and wait-state counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: count wait states while selected, abort to IDLE if PSEL drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT_STATES == 0 ? DONE : WAIT;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = cnt_q == 4'd1 ? DONE : WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response is formed on entry to DONE so it appears registered during the PREADY cycle.
    always_comb begin
        pready_d  = state_d == DONE;
        pslverr_d = pready_d && err;
        prdata_d  = pready_d && !err && !req_write ? rdata : '0;
    end

    // Request latch, GPIO registers, input synchroniser and registered response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            write_q   <= 1'b0;
            strb_q    <= '0;
            wdata_q   <= '0;
            out_q     <= '0;
            oe_q      <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            if (accept) begin
                addr_q  <= PADDR;
                write_q <= PWRITE;
                strb_q  <= PSTRB;
                wdata_q <= PWDATA;
            end
            out_q     <= out_d;
            oe_q      <= oe_d;
            sync1_q   <= gpio_in;
            sync2_q   <= sync1_q;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign PREADY   = pready_q;
    assign PSLVERR  = pslverr_q;
    assign PRDATA   = prdata_q;
    assign gpio_out = out_q;
    assign gpio_oe  = oe_q;
endmodule

// File: tb/tb_apb_gpio_completer.sv
// tb_apb_gpio_completer: checks a zero-wait and a three-wait completer against a response scoreboard.
module tb_apb_gpio_completer;
`ifdef APB_GPIO_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  psel = '0;
    logic        penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0, gpio_in = '0;
    logic [3:0]  pstrb = '0;
    logic        pready0, pready3, pslverr0, pslverr3;
    logic [31:0] prdata0, prdata3, out0, out3, oe0, oe3;
`ifdef APB_GPIO_IRQ_EN
    logic        irq0, irq3;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] rdata; logic err; } resp_t;
    typedef struct {
        bit w; logic [31:0] a; logic [3:0] s; logic [31:0] wd;
        logic [31:0] rd; bit er; logic [31:0] out; logic [31:0] oe;
    } vec_t;

    resp_t sb[$];
    vec_t  tv[$];

    always #5 clk = ~clk;

    apb_gpio_completer #(.WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .PSEL(psel[0]), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PSTRB(pstrb), .PWDATA(pwdata), .PRDATA(prdata0),
        .PREADY(pready0), .PSLVERR(pslverr0), .gpio_in(gpio_in),
        .gpio_out(out0), .gpio_oe(oe0)
`ifdef APB_GPIO_IRQ_EN
        , .irq(irq0)
`endif
    );

    apb_gpio_completer #(.WAIT_STATES(3), .BASE_ADDR(32'h1000)) u3 (
        .clk(clk), .rst(rst), .PSEL(psel[1]), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PSTRB(pstrb), .PWDATA(pwdata), .PRDATA(prdata3),
        .PREADY(pready3), .PSLVERR(pslverr3), .gpio_in(gpio_in),
        .gpio_out(out3), .gpio_oe(oe3)
`ifdef APB_GPIO_IRQ_EN
        , .irq(irq3)
`endif
    );

    function automatic logic rdy(input bit d);
        return d ? pready3 : pready0;
    endfunction

    function automatic logic [31:0] rdv(input bit d);
        return d ? prdata3 : prdata0;
    endfunction

    function automatic logic erv(input bit d);
        return d ? pslverr3 : pslverr0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One APB transfer; returns in the PREADY cycle so the next call can be back-to-back.
    task automatic xfer(input bit d, input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, input logic [31:0] erd, input bit eer, input string name);
        resp_t r;
        int    lat;
        @(negedge clk);
        psel    = d ? 2'b10 : 2'b01;
        penable = 1'b0;
        pwrite  = w;
        paddr   = a;
        pstrb   = s;
        pwdata  = wd;
        sb.push_back('{erd, eer});
        @(negedge clk);
        penable = 1'b1;
        lat = 1;
        while (!rdy(d) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = sb.pop_front();
        chk({name, " latency"}, 32'(lat), d ? 32'd4 : 32'd1);
        chk({name, " prdata"}, rdv(d), r.rdata);
        chk({name, " pslverr"}, 32'(erv(d)), 32'(r.err));
    endtask

    task automatic idle();
        @(negedge clk);
        psel    = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        tv.push_back('{1'b0, 32'h00, 4'hF, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0});
        tv.push_back('{1'b0, 32'h04, 4'hF, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0});
        tv.push_back('{1'b0, 32'h08, 4'hF, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0});
        tv.push_back('{1'b1, 32'h00, 4'b0101, 32'hDEADBEEF, 32'h0, 1'b0, 32'h00AD00EF, 32'h0});
        tv.push_back('{1'b0, 32'h00, 4'hF, 32'h0, 32'h00AD00EF, 1'b0, 32'h00AD00EF, 32'h0});
        tv.push_back('{1'b1, 32'h04, 4'hF, 32'h12345678, 32'h0, 1'b0, 32'h00AD00EF, 32'h12345678});
        tv.push_back('{1'b1, 32'h04, 4'b1000, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h00AD00EF, 32'hFF345678});
        tv.push_back('{1'b0, 32'h04, 4'hF, 32'h0, 32'hFF345678, 1'b0, 32'h00AD00EF, 32'hFF345678});
        tv.push_back('{1'b1, 32'h08, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h00AD00EF, 32'hFF345678});
        tv.push_back('{1'b0, 32'h14, 4'hF, 32'h0, 32'h0, 1'b1, 32'h00AD00EF, 32'hFF345678});
        tv.push_back('{1'b0, 32'h02, 4'hF, 32'h0, 32'h0, 1'b1, 32'h00AD00EF, 32'hFF345678});
        tv.push_back('{1'b1, 32'h01, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h00AD00EF, 32'hFF345678});
        tv.push_back('{1'b1, 32'h00, 4'h0, 32'h11223344, 32'h0, 1'b0, 32'h00AD00EF, 32'hFF345678});
        tv.push_back('{1'b1, 32'h0C, 4'hF, 32'h0, 32'h0, !HAS_IRQ, 32'h00AD00EF, 32'hFF345678});
        tv.push_back('{1'b0, 32'h0C, 4'hF, 32'h0, 32'h0, !HAS_IRQ, 32'h00AD00EF, 32'hFF345678});
        tv.push_back('{1'b0, 32'h10, 4'hF, 32'h0, 32'h0, !HAS_IRQ, 32'h00AD00EF, 32'hFF345678});

        repeat (3) @(negedge clk);
        chk("reset pready0", 32'(pready0), 32'd0);
        chk("reset pready3", 32'(pready3), 32'd0);
        chk("reset pslverr0", 32'(pslverr0), 32'd0);
        chk("reset prdata0", prdata0, 32'h0);
        chk("reset gpio_out0", out0, 32'h0);
        chk("reset gpio_oe3", oe3, 32'h0);
        rst = 1'b1;

        foreach (tv[i]) begin
            xfer(1'b0, tv[i].w, tv[i].a, tv[i].s, tv[i].wd, tv[i].rd, tv[i].er, $sformatf("vec%0d", i));
            idle();
            chk($sformatf("vec%0d gpio_out", i), out0, tv[i].out);
            chk($sformatf("vec%0d gpio_oe", i), oe0, tv[i].oe);
        end

        xfer(1'b0, 1'b1, 32'h00, 4'hF, 32'h000000FF, 32'h0, 1'b0, "b2b write");
        xfer(1'b0, 1'b0, 32'h00, 4'hF, 32'h0, 32'h000000FF, 1'b0, "b2b read");
        idle();
        chk("b2b gpio_out", out0, 32'h000000FF);

        @(negedge clk);
        gpio_in = 32'hA5A5A5A5;
        xfer(1'b0, 1'b0, 32'h08, 4'hF, 32'h0, 32'h0, 1'b0, "in 2nd edge");
        idle();
        xfer(1'b0, 1'b0, 32'h08, 4'hF, 32'h0, 32'hA5A5A5A5, 1'b0, "in settled");
        idle();
        gpio_in = 32'h5A5A5A5A;
        @(negedge clk);
        xfer(1'b0, 1'b0, 32'h08, 4'hF, 32'h0, 32'h5A5A5A5A, 1'b0, "in 3rd edge");
        idle();

        xfer(1'b1, 1'b1, 32'h1004, 4'hF, 32'h000000FF, 32'h0, 1'b0, "ws3 write oe");
        chk("ws3 oe before commit", oe3, 32'h0);
        idle();
        chk("ws3 oe after commit", oe3, 32'h000000FF);
        xfer(1'b1, 1'b0, 32'h1004, 4'hF, 32'h0, 32'h000000FF, 1'b0, "ws3 read oe");
        xfer(1'b1, 1'b0, 32'h0004, 4'hF, 32'h0, 32'h0, 1'b1, "ws3 below base");
        xfer(1'b1, 1'b0, 32'h1008, 4'hF, 32'h0, 32'h5A5A5A5A, 1'b0, "ws3 read in");
        idle();

        @(negedge clk);
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1000; pstrb = 4'hF; pwdata = 32'hFFFFFFFF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = '0; penable = 1'b0; pwrite = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (pready3) seen++;
        end
        chk("abort pready", 32'(seen), 32'd0);
        chk("abort gpio_out3", out3, 32'h0);
        xfer(1'b1, 1'b0, 32'h1000, 4'hF, 32'h0, 32'h0, 1'b0, "after abort");
        idle();

        @(negedge clk);
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1000; pstrb = 4'hF; pwdata = 32'hFFFFFFFF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset pready3", 32'(pready3), 32'd0);
        chk("midreset gpio_out0", out0, 32'h0);
        @(negedge clk);
        rst = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (pready3) seen++;
        end
        chk("midreset no pready", 32'(seen), 32'd0);
        chk("midreset gpio_out3", out3, 32'h0);
        xfer(1'b1, 1'b0, 32'h1000, 4'hF, 32'h0, 32'h0, 1'b0, "after midreset");
        idle();

`ifdef APB_GPIO_IRQ_EN
        gpio_in = '0;
        repeat (4) @(negedge clk);
        xfer(1'b0, 1'b1, 32'h10, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0, "irq clear all");
        idle();
        xfer(1'b0, 1'b1, 32'h0C, 4'hF, 32'h1, 32'h0, 1'b0, "irq enable");
        idle();
        repeat (2) @(negedge clk);
        chk("irq idle", 32'(irq0), 32'd0);
        gpio_in = 32'h1;
        repeat (2) @(negedge clk);
        gpio_in = '0;
        repeat (3) @(negedge clk);
        chk("irq raised", 32'(irq0), 32'd1);
        xfer(1'b0, 1'b0, 32'h10, 4'hF, 32'h0, 32'h1, 1'b0, "irq stat read");
        xfer(1'b0, 1'b1, 32'h10, 4'hF, 32'h1, 32'h0, 1'b0, "irq w1c");
        idle();
        @(negedge clk);
        chk("irq cleared", 32'(irq0), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
